wrr_hold_arbiter: RTL and testbench
===================================

Name: wrr_hold_arbiter

Overview:
- Weighted round-robin arbiter that shares one resource among N requesters.
- A winner keeps the grant for up to its programmed weight in consecutive cycles (tenure), or until it drops its request, whichever comes first.
- Ownership then rotates to the next requester after the current owner.
- Sits in front of the shared datapath in place of the plain single-cycle round-robin arbiter, wherever bursty masters need bounded hold times.

Parameters:
- N, 4, number of requesters (2..8).
- WW, 4, width of each weight field and of the tenure counter.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  asynchronous active-low reset.
- req  input  N  request vector, bit i = requester i; level-sensitive.
- weight  input  N*WW  packed weights, bits [i*WW +: WW] = max tenure of requester i in cycles; 0 treated as 1; sampled when the grant is issued.
- gnt  output  N  registered one-hot grant, all-zero when idle.
- gnt_id  output  $clog2(N)  index of the current owner, valid while busy.
- busy  output  1  high while any gnt bit is high.

Behaviour:
- Reset (rst=0, asynchronous): gnt=0, gnt_id=0, busy=0, state=IDLE, rr pointer ptr=0, tenure counter cnt=0. Reset mid-tenure drops gnt immediately, without waiting for a clock edge.
- The outputs gnt, gnt_id and busy are registered; no combinational path from req to gnt.
- Selection function pick(v, p): first set bit of v scanning p, p+1, ..., N-1, 0, ..., p-1 (mod N).
- State IDLE:
  - At a posedge with req!=0: owner = pick(req, ptr); gnt[owner]=1; gnt_id=owner; busy=1; cnt=1; lim = max(weight[owner], 1) latched; go to GRANT.
  - Grant latency from req first sampled high: 1 cycle.
- State GRANT, evaluated at each posedge:
  - release = (req[owner]==0) OR (cnt==lim).
  - If not release: cnt=cnt+1 and the grant holds.
  - If release:
    - ptr = owner+1 mod N.
    - Candidate vector c = req with bit owner cleared if req[owner]==0.
    - If req[owner]==1 and tenure expired, the owner stays in c, but scanning starts at owner+1, so it regains the grant only when it is the sole requester.
    - If c!=0: new owner = pick(c, owner+1); reload cnt=1 and lim in the same edge (zero-bubble handoff); stay in GRANT.
    - If c==0: gnt=0, busy=0, go to IDLE.
- Tenure: an owner holding req high sees gnt for exactly lim consecutive cycles before any rotation check.
- Early drop: if req drops, gnt falls at the first posedge that samples req low. There is at most one wasted grant cycle.
- Weight changes during a tenure have no effect until the next grant to that requester.
- cnt never exceeds lim, so WW-bit arithmetic cannot wrap. Weight (2^WW)-1 is the longest tenure.
- req bits of non-owners that toggle during a tenure are ignored; only their value at the release edge matters.
- gnt is always one-hot or zero.

Test Plan:
- Reset/idle:
  - Stimulus: rst=0 with req=4'b1111, then rst=1 with req=0 for 5 cycles.
  - Required: gnt=0 and busy=0 throughout; gnt=0 asynchronously on rst falling mid-grant.
- Single requester, weight 3:
  - Stimulus: req=4'b0001 held for 10 cycles.
  - Required: gnt=0001 continuously from 1 cycle after req; cnt reloads every 3 cycles; no gap; gnt_id=0.
- Full contention, weights {1,2,3,4} (req0..req3):
  - Stimulus: req=4'b1111 held.
  - Required: gnt sequence 0001 x1, 0010 x2, 0100 x3, 1000 x4, then repeats; no idle cycles.
- Early drop:
  - Stimulus: weight1=8, req=4'b0110; req1 deasserted after 2 granted cycles.
  - Required: gnt=0010 for 3 cycles, then 0100 with no bubble; ptr=2.
- Weight 0 and wrap:
  - Stimulus: weight3=0, req=4'b1001 held.
  - Required: grants alternate 0001/1000, each lasting exactly 1 cycle when weight0=1; rotation wraps from 3 to 0.
- Release to idle:
  - Stimulus: req=4'b0100 for 2 cycles, then 0.
  - Required: gnt=0100 for 2 cycles then 0; busy low one posedge after req low; next req=4'b0001 is granted 1 cycle later, searched from ptr=3.

Source files
------------

// File: rtl/wrr_hold_arbiter.sv
// Weighted round-robin arbiter with bounded hold: the owner keeps the grant for up
// to its weight in consecutive cycles, then ownership rotates past it.
module wrr_hold_arbiter #(
  parameter int N  = 4,
  parameter int WW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*WW-1:0]      weight,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy
);

  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [WW-1:0]   cnt, cnt_n;
  logic [WW-1:0]   lim, lim_n;
  logic [N-1:0]    gnt_n;
  logic [IW-1:0]   id_n;
  logic            busy_n;

  logic [WW-1:0]   wts [N];
  logic [IW-1:0]   start;
  logic [IW-1:0]   nxt;
  logic            resel;
  logic [IW:0]     sel;

  for (genvar g = 0; g < N; g++) begin : g_wts
    assign wts[g] = weight[g*WW +: WW];
  end

  // First set bit of v scanning from p upward with wrap; MSB of result flags a hit.
  function automatic logic [IW:0] pick(input logic [N-1:0] v, input logic [IW-1:0] p);
    logic [IW:0] res;
    int          j;
    res = '0;
    for (int k = N-1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= N) j = j - N;
      if (v[j[IW-1:0]]) res = {1'b1, j[IW-1:0]};
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ptr    <= '0;
      cnt    <= '0;
      lim    <= '0;
      gnt    <= '0;
      gnt_id <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      cnt    <= cnt_n;
      lim    <= lim_n;
      gnt    <= gnt_n;
      gnt_id <= id_n;
      busy   <= busy_n;
    end
  end

  // A reselection scans from ptr when idle and from owner+1 on release, so an
  // expired owner that still requests only wins again when nobody else asks.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    lim_n   = lim;
    gnt_n   = gnt;
    id_n    = gnt_id;
    busy_n  = busy;
    nxt     = (gnt_id == IW'(N-1)) ? '0 : gnt_id + IW'(1);
    start   = ptr;
    resel   = 1'b0;

    case (state)
      IDLE: resel = 1'b1;
      GRANT: begin
        if (req[gnt_id] && (cnt != lim)) begin
          cnt_n = cnt + WW'(1);
        end else begin
          start = nxt;
          ptr_n = nxt;
          resel = 1'b1;
        end
      end
      default: resel = 1'b1;
    endcase

    sel = pick(req, start);

    if (resel) begin
      if (sel[IW]) begin
        state_n          = GRANT;
        gnt_n            = '0;
        gnt_n[sel[IW-1:0]] = 1'b1;
        id_n             = sel[IW-1:0];
        busy_n           = 1'b1;
        cnt_n            = WW'(1);
        lim_n            = (wts[sel[IW-1:0]] == '0) ? WW'(1) : wts[sel[IW-1:0]];
      end else begin
        state_n = IDLE;
        gnt_n   = '0;
        busy_n  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wrr_hold_arbiter.sv
// Self-checking bench for wrr_hold_arbiter: directed scenarios against fixed
// grant tables, then random traffic against a cycle-level behavioural model.
module tb_wrr_hold_arbiter;

  localparam int N  = 4;
  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*WW-1:0] weight = '0;
  logic [N-1:0]  gnt;
  logic [1:0]    gnt_id;
  logic          busy;

  int checks = 0;
  int errors = 0;

  wrr_hold_arbiter #(.N(N), .WW(WW)) dut (
    .clk(clk), .rst(rst), .req(req), .weight(weight),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: owner index (-1 = idle), cycles held so far, tenure limit, rotation pointer.
  int m_owner = -1;
  int m_held  = 0;
  int m_lim   = 0;
  int m_ptr   = 0;

  function automatic int mpick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int mlim(input int i);
    int w;
    w = int'((weight >> (i * WW)) & 16'h000f);
    return (w == 0) ? 1 : w;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner = -1;
      m_held  = 0;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      if (req != 0) begin
        m_owner = mpick(req, m_ptr);
        m_held  = 1;
        m_lim   = mlim(m_owner);
      end
    end else if (req[m_owner] && m_held < m_lim) begin
      m_held = m_held + 1;
    end else begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = mpick(req, m_ptr);
      if (m_owner >= 0) begin
        m_held = 1;
        m_lim  = mlim(m_owner);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    weight = 16'hffff;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_hold cyc %0d: gnt=%b busy=%b, expected gnt=0000 busy=0", i, gnt, busy);
      end
    end
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_idle cyc %0d: gnt=%b busy=%b, expected gnt=0000 busy=0", i, gnt, busy);
      end
    end
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_pregrant: gnt=%b busy=%b, expected gnt=0001 busy=1", gnt, busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_async: gnt=%b busy=%b id=%0d, expected gnt=0000 busy=0 id=0", gnt, busy, gnt_id);
    end
    @(negedge clk);
    rst = 1'b1;
    req = '0;
  endtask

  task automatic test_single();
    do_reset();
    weight = 16'h0003;
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0001 || busy !== 1'b1 || gnt_id !== 2'd0) begin
        errors++;
        $display("[TB] FAIL single cyc %0d: gnt=%b busy=%b id=%0d, expected gnt=0001 busy=1 id=0", i, gnt, busy, gnt_id);
      end
    end
    req = '0;
  endtask

  task automatic test_contention();
    logic [3:0] pat [10];
    pat = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100,
            4'b1000, 4'b1000, 4'b1000, 4'b1000};
    do_reset();
    weight = {4'd4, 4'd3, 4'd2, 4'd1};
    req = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (gnt !== pat[i % 10] || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL contention cyc %0d: gnt=%b busy=%b, expected gnt=%b busy=1", i, gnt, busy, pat[i % 10]);
      end
    end
    req = '0;
  endtask

  task automatic test_early_drop();
    logic [3:0] pat [6];
    pat = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100};
    do_reset();
    weight = {4'd2, 4'd3, 4'd8, 4'd2};
    req = 4'b0110;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (gnt !== pat[i]) begin
        errors++;
        $display("[TB] FAIL early_drop cyc %0d: gnt=%b, expected %b", i, gnt, pat[i]);
      end
      if (i == 2) req = 4'b0100;
    end
    checks++;
    if (gnt_id !== 2'd2) begin
      errors++;
      $display("[TB] FAIL early_drop_id: gnt_id=%0d, expected 2", gnt_id);
    end
    req = '0;
  endtask

  task automatic test_weight0_wrap();
    logic [3:0] expg;
    do_reset();
    weight = {4'd0, 4'd5, 4'd5, 4'd1};
    req = 4'b1001;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      expg = (i % 2 == 0) ? 4'b0001 : 4'b1000;
      checks++;
      if (gnt !== expg || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL weight0_wrap cyc %0d: gnt=%b busy=%b, expected gnt=%b busy=1", i, gnt, busy, expg);
      end
    end
    req = '0;
  endtask

  task automatic test_release_idle();
    do_reset();
    weight = 16'h0400;
    req = 4'b0100;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
        errors++;
        $display("[TB] FAIL release_hold cyc %0d: gnt=%b id=%0d, expected gnt=0100 id=2", i, gnt, gnt_id);
      end
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release_idle: gnt=%b busy=%b, expected gnt=0000 busy=0", gnt, busy);
    end
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1 || gnt_id !== 2'd0) begin
      errors++;
      $display("[TB] FAIL release_regrant: gnt=%b busy=%b id=%0d, expected gnt=0001 busy=1 id=0", gnt, busy, gnt_id);
    end
    req = '0;
    @(negedge clk);
    req = 4'b1001;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL release_ptr: gnt=%b, expected 1000 after owner 0 released", gnt);
    end
    req = '0;
  endtask

  task automatic test_random();
    logic [3:0] expg;
    do_reset();
    weight = 16'h1234;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      expg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
      checks++;
      if (gnt !== expg || busy !== (m_owner >= 0)) begin
        errors++;
        $display("[TB] FAIL random cyc %0d: gnt=%b busy=%b, expected gnt=%b busy=%0d", i, gnt, busy, expg, m_owner >= 0);
      end
      if (m_owner >= 0) begin
        checks++;
        if (int'(gnt_id) != m_owner) begin
          errors++;
          $display("[TB] FAIL random_id cyc %0d: gnt_id=%0d, expected %0d", i, gnt_id, m_owner);
        end
      end
      if ($urandom_range(3) != 0) req = 4'($urandom_range(15));
      if ($urandom_range(9) == 0) weight = 16'($urandom);
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_early_drop();
    test_weight0_wrap();
    test_release_idle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
